// File: rtl/generic_fifo_ext.sv
// Parametrised synchronous FIFO with full/almost flags, occupancy count, sticky
// error flags, arbitrary depth and a registered or first-word fall-through read port.
module generic_fifo_ext #(
  parameter int GENERIC_FIFO_DEPTH        = 8,
  parameter int GENERIC_FIFO_DATA_WIDTH   = 32,
  parameter int GENERIC_FIFO_AF_THRESHOLD = 2,
  parameter int GENERIC_FIFO_AE_THRESHOLD = 1,
  parameter int GENERIC_FIFO_FWFT         = 0
) (
  input  logic                                       clk,
  input  logic                                       reset_poweron,
  input  logic                                       clear,
  input  logic                                       write,
  input  logic [GENERIC_FIFO_DATA_WIDTH-1:0]         write_data,
  input  logic                                       read,
  output logic [GENERIC_FIFO_DATA_WIDTH-1:0]         read_data,
  output logic                                       read_valid,
  output logic                                       empty,
  output logic                                       full,
  output logic                                       almost_full,
  output logic                                       almost_empty,
  output logic [$clog2(GENERIC_FIFO_DEPTH+1)-1:0]    count,
  output logic                                       overflow,
  output logic                                       underflow
);

  localparam int CW = $clog2(GENERIC_FIFO_DEPTH + 1);
  localparam int AW = $clog2(GENERIC_FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(GENERIC_FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(GENERIC_FIFO_DEPTH - 1);

  logic [GENERIC_FIFO_DATA_WIDTH-1:0] mem [GENERIC_FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          rd_acc;
  logic          wr_acc;
  logic          flush;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign flush  = reset_poweron | clear;
  assign rd_acc = read & (count != '0);
  assign wr_acc = write & ((count != DEPTH_C) | rd_acc);

  always_ff @(posedge clk) begin
    if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wp <= ptr_inc(wp);
      if (rd_acc) rp <= ptr_inc(rp);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write & ~wr_acc) overflow  <= 1'b1;
      if (read & ~rd_acc)  underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[wp] <= write_data;
  end

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = int'(DEPTH_C - count) <= GENERIC_FIFO_AF_THRESHOLD;
  assign almost_empty = int'(count) <= GENERIC_FIFO_AE_THRESHOLD;

  generate
    if (GENERIC_FIFO_FWFT != 0) begin : g_fwft
      // Head entry is presented directly; read acts as the pop acknowledge.
      assign read_data  = mem[rp];
      assign read_valid = ~empty;
    end else begin : g_reg
      logic [GENERIC_FIFO_DATA_WIDTH-1:0] rdata_p1;
      logic                               vld_p1;

      // p0 -> p1: pop data registered one cycle after the accepted read.
      always_ff @(posedge clk) begin
        if (reset_poweron) begin
          rdata_p1 <= '0;
          vld_p1   <= 1'b0;
        end else if (clear) begin
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rdata_p1 <= mem[rp];
        end
      end

      assign read_data  = rdata_p1;
      assign read_valid = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_generic_fifo_ext.sv
// Bench for generic_fifo_ext: a DEPTH=8 registered-read instance and a DEPTH=5
// FWFT instance share stimulus and are checked against queue-based models.
module tb_generic_fifo_ext;

  localparam int DA = 8, AFA = 2, AEA = 1;
  localparam int DB = 5, AFB = 1, AEB = 2;

  logic        clk = 1'b0;
  logic        reset_poweron = 1'b0;
  logic        clear = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] write_data = '0;

  logic [31:0] a_rd, b_rd;
  logic        a_rv, a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
  logic        b_rv, b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
  logic [3:0]  a_count;
  logic [2:0]  b_count;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          ova, una, rva, ovb, unb;
  logic [31:0] rda;

  always #5 clk = ~clk;

  generic_fifo_ext #(.GENERIC_FIFO_DEPTH(DA), .GENERIC_FIFO_DATA_WIDTH(32),
    .GENERIC_FIFO_AF_THRESHOLD(AFA), .GENERIC_FIFO_AE_THRESHOLD(AEA),
    .GENERIC_FIFO_FWFT(0)) dut_a (
    .clk(clk), .reset_poweron(reset_poweron), .clear(clear), .write(write),
    .write_data(write_data), .read(read), .read_data(a_rd), .read_valid(a_rv),
    .empty(a_empty), .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf));

  generic_fifo_ext #(.GENERIC_FIFO_DEPTH(DB), .GENERIC_FIFO_DATA_WIDTH(32),
    .GENERIC_FIFO_AF_THRESHOLD(AFB), .GENERIC_FIFO_AE_THRESHOLD(AEB),
    .GENERIC_FIFO_FWFT(1)) dut_b (
    .clk(clk), .reset_poweron(reset_poweron), .clear(clear), .write(write),
    .write_data(write_data), .read(read), .read_data(b_rd), .read_valid(b_rv),
    .empty(b_empty), .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf));

  logic [10:0] act_a;
  logic [9:0]  act_b;
  assign act_a = {a_empty, a_full, a_af, a_ae, a_ovf, a_unf, a_rv, a_count};
  assign act_b = {b_empty, b_full, b_af, b_ae, b_ovf, b_unf, b_rv, b_count};

  function automatic logic [10:0] exp_a();
    int n = qa.size();
    return {n == 0, n == DA, (DA - n) <= AFA, n <= AEA, ova, una, rva, 4'(n)};
  endfunction

  function automatic logic [9:0] exp_b();
    int n = qb.size();
    return {n == 0, n == DB, (DB - n) <= AFB, n <= AEB, ovb, unb, n != 0, 3'(n)};
  endfunction

  // One clock: drive on the falling edge, advance the models at the rising edge,
  // leave the caller 1 time unit after the edge to sample outputs.
  task automatic tick(input bit rst, input bit clr, input bit wr, input bit rd,
                      input logic [31:0] d);
    bit ra, wa;
    @(negedge clk);
    reset_poweron = rst; clear = clr; write = wr; read = rd; write_data = d;
    @(posedge clk);
    if (rst || clr) begin
      qa.delete(); qb.delete();
      ova = 0; una = 0; rva = 0; ovb = 0; unb = 0;
      if (rst) rda = '0;
    end else begin
      ra = rd && qa.size() != 0;
      wa = wr && (qa.size() != DA || ra);
      rva = ra;
      if (ra) rda = qa.pop_front();
      if (wa) qa.push_back(d);
      if (wr && !wa) ova = 1;
      if (rd && !ra) una = 1;
      ra = rd && qb.size() != 0;
      wa = wr && (qb.size() != DB || ra);
      if (ra) void'(qb.pop_front());
      if (wa) qb.push_back(d);
      if (wr && !wa) ovb = 1;
      if (rd && !ra) unb = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    compared++;
    if (act_a !== 11'b1001_000_0000 || a_rd !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_a: status=%b data=%h, required status=10010000000 data=0", act_a, a_rd);
    end
    compared++;
    if (act_b !== 10'b1001_000_000) begin
      mismatched++;
      $display("FAIL reset_b: status=%b, required 1001000000", act_b);
    end
  endtask

  task automatic test_fill_drain();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 32'h10 + i);
    compared++;
    if (act_a !== 11'b0110_000_1000) begin
      mismatched++;
      $display("FAIL fill_status: got %b, required 01100001000", act_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 1, 0);
      compared++;
      if ({a_rv, a_rd} !== {1'b1, 32'h10 + i}) begin
        mismatched++;
        $display("FAIL drain_%0d: valid=%b data=%h, required valid=1 data=%h", i, a_rv, a_rd, 32'h10 + i);
      end
    end
    tick(0, 0, 0, 0, 0);
    compared++;
    if ({a_rv, a_empty} !== 2'b01) begin
      mismatched++;
      $display("FAIL drain_end: valid=%b empty=%b, required valid=0 empty=1", a_rv, a_empty);
    end
  endtask

  task automatic test_errors();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, i);
    tick(0, 0, 1, 0, 32'h99);
    compared++;
    if ({a_count, a_ovf} !== {4'd8, 1'b1}) begin
      mismatched++;
      $display("FAIL overflow: count=%0d ovf=%b, required count=8 ovf=1", a_count, a_ovf);
    end
    tick(0, 0, 0, 0, 0);
    compared++;
    if (a_ovf !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_sticky: ovf=%b, required 1", a_ovf);
    end
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    compared++;
    if ({a_unf, a_rv} !== 2'b10) begin
      mismatched++;
      $display("FAIL underflow: unf=%b valid=%b, required unf=1 valid=0", a_unf, a_rv);
    end
    tick(0, 1, 0, 0, 0);
    compared++;
    if ({a_ovf, a_unf, a_count, a_empty, a_rd} !== {2'b00, 4'd0, 1'b1, 32'd7}) begin
      mismatched++;
      $display("FAIL clear: ovf=%b unf=%b count=%0d empty=%b data=%h, required 0 0 0 1 00000007",
               a_ovf, a_unf, a_count, a_empty, a_rd);
    end
  endtask

  task automatic test_full_rw();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 32'h50 + i);
    tick(0, 0, 1, 1, 32'hAA);
    compared++;
    if ({a_count, a_ovf, a_rv, a_rd} !== {4'd8, 1'b0, 1'b1, 32'h50}) begin
      mismatched++;
      $display("FAIL full_rw: count=%0d ovf=%b valid=%b data=%h, required 8 0 1 00000050",
               a_count, a_ovf, a_rv, a_rd);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 1, 0);
      compared++;
      if (a_rd !== ((i == 7) ? 32'hAA : 32'h51 + i)) begin
        mismatched++;
        $display("FAIL full_rw_pop_%0d: data=%h, required %h", i, a_rd,
                 (i == 7) ? 32'hAA : 32'h51 + i);
      end
    end
    tick(0, 0, 1, 1, 32'h5);
    compared++;
    if ({a_count, a_unf, a_rv} !== {4'd1, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL empty_rw: count=%0d unf=%b valid=%b, required 1 1 0", a_count, a_unf, a_rv);
    end
  endtask

  task automatic test_fwft();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 32'h33);
    compared++;
    if ({b_rv, b_rd} !== {1'b1, 32'h33}) begin
      mismatched++;
      $display("FAIL fwft_first: valid=%b data=%h, required 1 00000033", b_rv, b_rd);
    end
    tick(0, 0, 1, 0, 32'h44);
    compared++;
    if ({b_rv, b_rd, b_count} !== {1'b1, 32'h33, 3'd2}) begin
      mismatched++;
      $display("FAIL fwft_hold: valid=%b data=%h count=%0d, required 1 00000033 2", b_rv, b_rd, b_count);
    end
    tick(0, 0, 0, 1, 0);
    compared++;
    if ({b_rv, b_rd} !== {1'b1, 32'h44}) begin
      mismatched++;
      $display("FAIL fwft_pop: valid=%b data=%h, required 1 00000044", b_rv, b_rd);
    end
    tick(0, 0, 0, 1, 0);
    compared++;
    if ({b_rv, b_empty} !== 2'b01) begin
      mismatched++;
      $display("FAIL fwft_empty: valid=%b empty=%b, required 0 1", b_rv, b_empty);
    end
  endtask

  task automatic test_wrap_depth5();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, $urandom);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, ($urandom % 10) < 6, ($urandom % 10) < 5, $urandom);
      compared++;
      if (act_b !== exp_b() || (qb.size() != 0 && b_rd !== qb[0])) begin
        mismatched++;
        $display("FAIL wrap5_%0d: status=%b data=%h, required status=%b data=%h", i,
                 act_b, b_rd, exp_b(), (qb.size() != 0) ? qb[0] : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 32'hC0 + i);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 1, 0, 32'hC3);
    tick(1, 0, 1, 1, 32'hEE);
    compared++;
    if (act_a !== 11'b1001_000_0000 || a_rd !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid: status=%b data=%h, required 10010000000 00000000", act_a, a_rd);
    end
    tick(0, 0, 0, 1, 0);
    compared++;
    if ({a_rv, a_unf, a_empty} !== 3'b011) begin
      mismatched++;
      $display("FAIL reset_discard: valid=%b unf=%b empty=%b, required 0 1 1", a_rv, a_unf, a_empty);
    end
  endtask

  task automatic test_random();
    int wbias, rbias;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      wbias = ((i / 50) % 2 == 0) ? 7 : 3;
      rbias = 10 - wbias;
      tick(($urandom % 97) == 0, ($urandom % 50) == 0,
           ($urandom % 10) < wbias, ($urandom % 10) < rbias, $urandom);
      compared++;
      if (act_a !== exp_a() || a_rd !== rda) begin
        mismatched++;
        $display("FAIL rand_a_%0d: status=%b data=%h, required status=%b data=%h", i,
                 act_a, a_rd, exp_a(), rda);
      end
      compared++;
      if (act_b !== exp_b() || (qb.size() != 0 && b_rd !== qb[0])) begin
        mismatched++;
        $display("FAIL rand_b_%0d: status=%b data=%h, required status=%b data=%h", i,
                 act_b, b_rd, exp_b(), (qb.size() != 0) ? qb[0] : 32'h0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_full_rw();
    test_fwft();
    test_wrap_depth5();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
